key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter T_DB, default 1000000, meaning the number of consecutive stable samples needed to accept a press or a release (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter T_LONG, default 50000000, meaning the number of clock cycles a key must be held, counted from its k_press, before k_long fires.
REQ-003 The block SHALL have port clk, input, width 1: the single system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port key_in, input, width 2: raw mechanical key levels, asynchronous to clk, 1 = pressed; bit0 = k1, bit1 = k2.
REQ-006 The block SHALL have port k_level, output, width 2: debounced key level per key; this is the k1/k2 drive for led_3color.
REQ-007 The block SHALL have port k_press, output, width 2: one-cycle pulse per key on an accepted press.
REQ-008 The block SHALL have port k_release, output, width 2: one-cycle pulse per key on an accepted release.
REQ-009 The block SHALL have port k_long, output, width 2: one-cycle pulse per key when the long-press threshold is reached.

Function
REQ-010 Each key_in bit SHALL pass through a 2-flop synchronizer; the FSM sees the second-flop output (s).
REQ-011 The two keys SHALL be fully independent: separate synchronizer, FSM, debounce counter and long counter per key.
REQ-012 The per-key FSM SHALL have four states: IDLE (k_level=0), PRESS_WAIT, PRESSED (k_level=1), RELEASE_WAIT.
REQ-013 From IDLE, on s=1 the FSM SHALL go to PRESS_WAIT with the debounce counter set to 1; otherwise it SHALL stay in IDLE.
REQ-014 In PRESS_WAIT, s=0 SHALL return the FSM to IDLE and clear the counter with no output event; s=1 SHALL increment the counter.
REQ-015 In PRESS_WAIT, when the counter reaches T_DB, the FSM SHALL go to PRESSED, set k_level=1, pulse k_press for exactly one cycle, and clear the long counter.
REQ-016 Press latency SHALL be as follows: if key_in is first sampled high at edge E0 and stays high, k_level and k_press change on edge E0+T_DB+1.
REQ-017 In PRESSED, the long counter SHALL increment every cycle; on the edge it reaches T_LONG, k_long SHALL pulse once, after which the counter saturates and k_long does not repeat during that press.
REQ-018 In PRESSED, s=0 SHALL move the FSM to RELEASE_WAIT with the debounce counter set to 1.
REQ-019 In RELEASE_WAIT, s=1 SHALL return the FSM to PRESSED with no event; k_level stays 1 and the long counter keeps counting (it is not cleared).
REQ-020 In RELEASE_WAIT, s=0 SHALL increment the counter; when the counter reaches T_DB, the FSM SHALL go to IDLE, set k_level=0 and pulse k_release for one cycle.
REQ-021 The long counter SHALL also run in RELEASE_WAIT.
REQ-022 Any glitch shorter than T_DB samples SHALL produce no change on any output.
REQ-023 k_release SHALL follow every k_press, including presses that produced k_long.
REQ-024 Each key SHALL never assert k_press and k_release in the same cycle.
REQ-025 Simultaneous presses on both keys with identical timing SHALL produce identical, same-cycle pulses on both bits.
REQ-026 Counter widths SHALL be $clog2(parameter+1), and counters SHALL never wrap.
REQ-027 Legal parameters SHALL be T_DB >= 1 and T_LONG >= 1; no other range is supported.

Reset
REQ-028 With rst=1 at a clock edge, all synchronizer flops, FSMs (to IDLE) and counters SHALL clear, and k_level, k_press, k_release and k_long SHALL be 0 after that edge.
REQ-029 Reset mid-press SHALL give no k_release pulse.
REQ-030 After rst deasserts, a key still held SHALL be detected as a new press with the full REQ-016 latency.

Verification (T_DB=3, T_LONG=10 via defparam, 20 ns clock)
REQ-031 Clean step: key_in[0] 0->1 sampled at edge E0 and held -> k_press[0]=1 for one cycle and k_level[0]=1 after edge E0+4; no other output changes.
REQ-032 Bounce: key_in[0] toggles every clock for 8 cycles, then stays 0 -> no pulse on any output; k_level stays 00.
REQ-033 Long press: hold key_in[1] -> k_long[1] pulses once 10 edges after k_press[1]; it does not pulse again while held. Release -> k_release[1] on edge R0+4 (R0 = first low sample).
REQ-034 Release bounce: while pressed, drop key_in[0] for 2 cycles then restore -> no k_release; k_level stays 1.
REQ-035 Both keys: press both in the same cycle -> k_press=11 in one cycle; releases are independent.
REQ-036 Reset mid-press: assert rst for 1 cycle while k_level[0]=1 with key still held -> outputs 0 with no k_release; a new k_press[0] appears 4 edges after the first post-reset sample.

Source files
------------

// File: rtl/key_debounce.sv
// Two-key debouncer: per-key synchronizer, press/release FSM, debounce and long-press timers.
// Outputs are registered: debounced level plus one-cycle press, release and long-press pulses.

module key_debounce_ch #(
    parameter int T_DB   = 1000000,
    parameter int T_LONG = 50000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);
    // state        | meaning
    // IDLE         | key released, k_level=0
    // PRESS_WAIT   | high samples being counted toward acceptance
    // PRESSED      | key accepted as pressed, k_level=1
    // RELEASE_WAIT | low samples being counted toward release, k_level=1
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int DW = $clog2(T_DB + 1);
    localparam int LW = $clog2(T_LONG + 1);
    localparam logic [DW-1:0] DB_ONE_V  = DW'(1);
    localparam logic [DW-1:0] DB_LAST   = DW'(T_DB - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(T_LONG - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(T_LONG);
    // With a single-sample debounce the first stable sample already qualifies.
    localparam bit DB_IMMEDIATE = (T_DB == 1);

    state_t          state_q;
    logic [1:0]      sync_q;
    logic [DW-1:0]   db_cnt_q;
    logic [LW-1:0]   long_cnt_q;
    logic            level_q;
    logic            press_q;
    logic            release_q;
    logic            long_q;
    logic            s;

    assign s = sync_q[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q     <= 2'b00;
            state_q    <= IDLE;
            db_cnt_q   <= '0;
            long_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_i};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;

            // Hold timer runs across release bounces and saturates at T_LONG.
            if ((state_q == PRESSED || state_q == RELEASE_WAIT) && long_cnt_q != LONG_MAX) begin
                long_cnt_q <= long_cnt_q + 1'b1;
                if (long_cnt_q == LONG_LAST) begin
                    long_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    long_cnt_q <= '0;
                    if (s) begin
                        if (DB_IMMEDIATE) begin
                            state_q  <= PRESSED;
                            level_q  <= 1'b1;
                            press_q  <= 1'b1;
                            db_cnt_q <= '0;
                        end else begin
                            state_q  <= PRESS_WAIT;
                            db_cnt_q <= DB_ONE_V;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_q  <= IDLE;
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q    <= PRESSED;
                        level_q    <= 1'b1;
                        press_q    <= 1'b1;
                        db_cnt_q   <= '0;
                        long_cnt_q <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        if (DB_IMMEDIATE) begin
                            state_q   <= IDLE;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                            db_cnt_q  <= '0;
                        end else begin
                            state_q  <= RELEASE_WAIT;
                            db_cnt_q <= DB_ONE_V;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state_q  <= PRESSED;
                        db_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q   <= IDLE;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                        db_cnt_q  <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    level_q  <= 1'b0;
                    db_cnt_q <= '0;
                end
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
endmodule

module key_debounce #(
    parameter int T_DB   = 1000000,
    parameter int T_LONG = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] key_in,
    output logic [1:0] k_level,
    output logic [1:0] k_press,
    output logic [1:0] k_release,
    output logic [1:0] k_long
);
    // Keys are fully independent channels; bit0 = k1, bit1 = k2.
    for (genvar g = 0; g < 2; g++) begin : g_key
        key_debounce_ch #(
            .T_DB  (T_DB),
            .T_LONG(T_LONG)
        ) u_ch (
            .clk_i    (clk),
            .rst_i    (rst),
            .key_i    (key_in[g]),
            .level_o  (k_level[g]),
            .press_o  (k_press[g]),
            .release_o(k_release[g]),
            .long_o   (k_long[g])
        );
    end
endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with T_DB=3, T_LONG=10: expected pulse/level events are
// queued by cycle when keys are driven and compared against the outputs every cycle.

module tb_key_debounce;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key_in;
    logic [1:0] k_level, k_press, k_release, k_long;

    key_debounce #(.T_DB(3), .T_LONG(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .k_level  (k_level),
        .k_press  (k_press),
        .k_release(k_release),
        .k_long   (k_long)
    );

    always #10 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [5:0] pul;   // {long[1:0], release[1:0], press[1:0]}
        logic [1:0] m;     // keys whose level is updated at this cycle
        logic [1:0] v;     // new level for those keys
    } ev_t;

    ev_t        sb[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    bit         mon_en = 1'b0;
    logic [1:0] exp_lvl = 2'b00;
    ev_t        mon_e;
    logic [5:0] mon_ep;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [5:0] p, input logic [1:0] m, input logic [1:0] v);
        int  pos;
        ev_t e;
        pos = 0;
        while (pos < sb.size() && sb[pos].cyc < c) pos++;
        if (pos < sb.size() && sb[pos].cyc == c) begin
            e     = sb[pos];
            e.pul = e.pul | p;
            e.v   = (e.v & ~m) | (v & m);
            e.m   = e.m | m;
            sb[pos] = e;
        end else begin
            e.cyc = c;
            e.pul = p;
            e.m   = m;
            e.v   = v;
            sb.insert(pos, e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse vector helpers for key k.
    function automatic logic [5:0] P(input int k); return 6'(1 << k);  endfunction
    function automatic logic [5:0] R(input int k); return 6'(4 << k);  endfunction
    function automatic logic [5:0] L(input int k); return 6'(16 << k); endfunction
    function automatic logic [1:0] B(input int k); return 2'(1 << k);  endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            mon_ep = '0;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_e   = sb.pop_front();
                mon_ep  = mon_e.pul;
                exp_lvl = (exp_lvl & ~mon_e.m) | (mon_e.v & mon_e.m);
            end
            check("pulses", {26'b0, k_long, k_release, k_press}, {26'b0, mon_ep});
            check("level", {30'b0, k_level}, {30'b0, exp_lvl});
        end
    end

    // A key driven at the negedge of cycle c is first sampled at edge c+1 and accepted at c+5.
    initial begin
        int c;
        rst    = 1'b1;
        key_in = 2'b00;
        step(2);
        rst    = 1'b0;
        check("rst_outputs", {24'b0, k_level, k_press, k_release, k_long}, 32'h0);
        mon_en = 1'b1;
        step(2);

        // Clean step on k1, short hold, release.
        c = cyc; key_in[0] = 1'b1;
        push(c + 5, P(0), B(0), B(0));
        step(8);
        c = cyc; key_in[0] = 1'b0;
        push(c + 5, R(0), B(0), 2'b00);
        step(8);

        // Bounce on k1: toggles every clock, never stable long enough.
        for (int i = 0; i < 8; i++) begin
            key_in[0] = ~key_in[0];
            step(1);
        end
        key_in[0] = 1'b0;
        step(6);

        // Long press on k2: single k_long 10 edges after k_press, release later.
        c = cyc; key_in[1] = 1'b1;
        push(c + 5, P(1), B(1), B(1));
        push(c + 15, L(1), 2'b00, 2'b00);
        step(20);
        c = cyc; key_in[1] = 1'b0;
        push(c + 5, R(1), B(1), 2'b00);
        step(8);

        // Release bounce on k1: 2-cycle drop, long counter must keep running through it.
        c = cyc; key_in[0] = 1'b1;
        push(c + 5, P(0), B(0), B(0));
        push(c + 15, L(0), 2'b00, 2'b00);
        step(7);
        key_in[0] = 1'b0;
        step(2);
        key_in[0] = 1'b1;
        step(11);
        c = cyc; key_in[0] = 1'b0;
        push(c + 5, R(0), B(0), 2'b00);
        step(8);

        // Both keys pressed together, released independently.
        c = cyc; key_in = 2'b11;
        push(c + 5, P(0) | P(1), 2'b11, 2'b11);
        step(6);
        key_in[0] = 1'b0;
        push(c + 11, R(0), B(0), 2'b00);
        step(2);
        key_in[1] = 1'b0;
        push(c + 13, R(1), B(1), 2'b00);
        step(8);

        // Debounce boundary on k2: 2 high samples rejected, exactly 3 accepted.
        key_in[1] = 1'b1;
        step(2);
        key_in[1] = 1'b0;
        step(6);
        c = cyc; key_in[1] = 1'b1;
        push(c + 5, P(1), B(1), B(1));
        step(3);
        key_in[1] = 1'b0;
        push(c + 8, R(1), B(1), 2'b00);
        step(10);

        // Reset mid-press on k1 with key held: no release, fresh press with full latency.
        c = cyc; key_in[0] = 1'b1;
        push(c + 5, P(0), B(0), B(0));
        step(8);
        rst = 1'b1;
        push(c + 9, 6'b0, 2'b11, 2'b00);
        step(1);
        rst = 1'b0;
        push(c + 14, P(0), B(0), B(0));
        step(7);
        c = cyc; key_in[0] = 1'b0;
        push(c + 5, R(0), B(0), 2'b00);
        step(16);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
